// File: rtl/collision_probe.sv
// Four-corner hitbox probe: walks TL, TR, BL, BR of a BOX_W x BOX_H box through the
// level map's single collision port and returns one solid/empty bit per corner.
module collision_probe #(
    parameter int BOX_W = 32,
    parameter int BOX_H = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic [9:0] q_x,
    output logic [9:0] q_y,
    input  logic       q_data,
    output logic       busy,
    output logic       done,
    output logic [3:0] hit,
    output logic       any_hit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Box extents reduced to 10 bits so corner sums wrap modulo 1024.
    localparam logic [9:0] DX = 10'(BOX_W - 1);
    localparam logic [9:0] DY = 10'(BOX_H - 1);

    state_t     state;
    logic [1:0] idx;
    logic [9:0] base_x;
    logic [9:0] base_y;
    logic [9:0] next_x;
    logic [9:0] next_y;

    // Corner that follows the one currently presented on q_x/q_y.
    always_comb begin
        next_x = base_x;
        next_y = base_y;
        case (idx)
            2'd0: begin
                next_x = base_x + DX;
                next_y = base_y;
            end
            2'd1: begin
                next_x = base_x;
                next_y = base_y + DY;
            end
            default: begin
                next_x = base_x + DX;
                next_y = base_y + DY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            base_x <= 10'd0;
            base_y <= 10'd0;
            q_x    <= 10'd0;
            q_y    <= 10'd0;
            hit    <= 4'd0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_x <= px;
                        base_y <= py;
                        q_x    <= px;
                        q_y    <= py;
                        hit    <= 4'd0;
                        idx    <= 2'd0;
                        state  <= PROBE;
                    end
                end
                PROBE: begin
                    hit[idx] <= q_data;
                    if (idx == 2'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 2'd1;
                        q_x <= next_x;
                        q_y <= next_y;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign any_hit = |hit;

endmodule

// File: tb/tb_collision_probe.sv
// Scoreboard bench for collision_probe: a posedge reference model queues expected probes,
// a negedge monitor compares every cycle; the level map is emulated from a tile bit array.
module tb_collision_probe;

    localparam int BOX_W  = 32;
    localparam int BOX_H  = 32;
    localparam int MAP_X0 = 128;
    localparam int MAP_Y0 = 32;
    localparam int TILE   = 32;
    localparam int COLS   = 16;
    localparam int ROWS   = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] q_x;
    logic [9:0] q_y;
    logic       q_data;
    logic       busy;
    logic       done;
    logic [3:0] hit;
    logic       any_hit;

    logic [COLS*ROWS-1:0] tile_bits;

    typedef struct packed {
        logic [31:0]      e0;
        logic [3:0]       hit;
        logic [3:0][9:0]  cx;
        logic [3:0][9:0]  cy;
    } txn_t;

    txn_t sb[$];

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int next_free = 0;
    int done_seen = 0;
    logic [3:0] held_hit = 4'd0;
    logic [9:0] held_qx = 10'd0;
    logic [9:0] held_qy = 10'd0;

    always #5 clk = ~clk;

    collision_probe #(.BOX_W(BOX_W), .BOX_H(BOX_H)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .px     (px),
        .py     (py),
        .q_x    (q_x),
        .q_y    (q_y),
        .q_data (q_data),
        .busy   (busy),
        .done   (done),
        .hit    (hit),
        .any_hit(any_hit)
    );

    // Level map emulation: anything outside the tile grid reads as solid.
    always_comb begin
        q_data = 1'b1;
        if (int'(q_x) >= MAP_X0 && int'(q_x) < MAP_X0 + COLS*TILE &&
            int'(q_y) >= MAP_Y0 && int'(q_y) < MAP_Y0 + ROWS*TILE)
            q_data = tile_bits[((int'(q_y) - MAP_Y0) / TILE) * COLS + (int'(q_x) - MAP_X0) / TILE];
    end

    function automatic logic map_bit(input int x, input int y);
        if (x < MAP_X0 || x >= MAP_X0 + COLS*TILE || y < MAP_Y0 || y >= MAP_Y0 + ROWS*TILE)
            return 1'b1;
        return tile_bits[((y - MAP_Y0) / TILE) * COLS + (x - MAP_X0) / TILE];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h edge=%0d", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: a request is taken when the probe engine is free; a probe
    // occupies the accepting edge plus five more before another can be taken.
    always @(posedge clk) begin : model
        txn_t t;
        int   x;
        int   y;
        edge_cnt++;
        if (reset) begin
            sb.delete();
            next_free = edge_cnt + 1;
            held_hit  = 4'd0;
            held_qx   = 10'd0;
            held_qy   = 10'd0;
        end else if (start && edge_cnt >= next_free) begin
            t = '0;
            t.e0 = 32'(edge_cnt);
            for (int c = 0; c < 4; c++) begin
                x = (int'(px) + ((c % 2 == 1) ? BOX_W - 1 : 0)) % 1024;
                y = (int'(py) + ((c >= 2) ? BOX_H - 1 : 0)) % 1024;
                t.cx[c]  = 10'(x);
                t.cy[c]  = 10'(y);
                t.hit[c] = map_bit(x, y);
            end
            sb.push_back(t);
            next_free = edge_cnt + 6;
        end
    end

    always @(negedge clk) begin : monitor
        int off;
        int k;
        if (sb.size() > 0) begin
            off = edge_cnt - int'(sb[0].e0);
            k = (off > 3) ? 3 : off;
            check_output("busy_active", busy, 1);
            check_output("done_timing", done, (off == 4) ? 1 : 0);
            check_output("query_x", q_x, sb[0].cx[k]);
            check_output("query_y", q_y, sb[0].cy[k]);
            if (off >= 4) begin
                check_output("hit", hit, sb[0].hit);
                check_output("any_hit", any_hit, |sb[0].hit);
                held_hit = sb[0].hit;
                held_qx  = sb[0].cx[3];
                held_qy  = sb[0].cy[3];
                void'(sb.pop_front());
            end
        end else begin
            check_output("busy_idle", busy, 0);
            check_output("done_idle", done, 0);
            check_output("hit_hold", hit, held_hit);
            check_output("any_hit_hold", any_hit, |held_hit);
            check_output("qx_hold", q_x, held_qx);
            check_output("qy_hold", q_y, held_qy);
        end
        if (done === 1'b1)
            done_seen++;
    end

    task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y, input int hold);
        @(negedge clk);
        px    = x;
        py    = y;
        start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_timeout actual=%0d pending required=0 pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Single-pulse probe with fixed-latency and constant-result checks.
    task automatic run_directed(input string name, input logic [9:0] x, input logic [9:0] y,
                                input logic [3:0] exp_hit, input logic [9:0] exp_qx,
                                input logic [9:0] exp_qy);
        apply_stimulus(x, y, 1);
        repeat (3) @(posedge clk);
        #1;
        check_output({name, "_no_early_done"}, done, 0);
        @(posedge clk);
        #1;
        check_output({name, "_done"}, done, 1);
        check_output({name, "_hit"}, hit, exp_hit);
        check_output({name, "_any"}, any_hit, |exp_hit);
        check_output({name, "_br_x"}, q_x, exp_qx);
        check_output({name, "_br_y"}, q_y, exp_qy);
        @(posedge clk);
        #1;
        check_output({name, "_done_drop"}, done, 0);
        check_output({name, "_busy_drop"}, busy, 0);
        wait_idle();
    endtask

    initial begin
        int d0;
        int hold;
        reset     = 1'b1;
        start     = 1'b0;
        px        = 10'd0;
        py        = 10'd0;
        tile_bits = '0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_hit", hit, 0);
        check_output("rst_qx", q_x, 0);
        check_output("rst_qy", q_y, 0);
        reset = 1'b0;

        tile_bits[0] = 1'b1;
        run_directed("solid_corner", 10'd144, 10'd35, 4'b0001, 10'd175, 10'd66);
        tile_bits = '0;
        run_directed("open_area", 10'd208, 10'd99, 4'b0000, 10'd239, 10'd130);
        run_directed("out_of_map", 10'd100, 10'd99, 4'b0101, 10'd131, 10'd130);
        run_directed("wrap", 10'd1020, 10'd1020, 4'b1111, 10'd27, 10'd27);

        // Start held high: exactly two probes complete within the window.
        d0 = done_seen;
        apply_stimulus(10'd208, 10'd99, 12);
        repeat (8) @(negedge clk);
        check_output("held_start_done_count", 32'(done_seen - d0), 2);
        wait_idle();

        // Reset two edges into a probe aborts it without a done pulse.
        d0 = done_seen;
        apply_stimulus(10'd300, 10'd200, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_hit", hit, 0);
        check_output("abort_qx", q_x, 0);
        check_output("abort_qy", q_y, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_output("abort_no_done", 32'(done_seen - d0), 0);
        run_directed("after_abort", 10'd208, 10'd99, 4'b0000, 10'd239, 10'd130);

        // Start coinciding with reset is dropped.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_output("start_during_reset", busy, 0);

        for (int n = 0; n < 40; n++) begin
            for (int b = 0; b < COLS*ROWS; b++)
                tile_bits[b] = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 7) == 0)
                apply_stimulus(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 0);
            else
                apply_stimulus(10'($urandom_range(96, 640)), 10'($urandom_range(0, 420)), 0);
            start = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    px = 10'($urandom_range(0, 1023));
                    py = 10'($urandom_range(0, 1023));
                end
            end
            start = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
